// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter/sequencer.
package alu_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int ALU_W   = 8;
  localparam int ALU_OPW = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response channels of alu_arbiter; slave = arbiter side.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) ();
  logic             r0_valid;
  logic             r0_ready;
  logic [OPW-1:0]   r0_op;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r1_valid;
  logic             r1_ready;
  logic [OPW-1:0]   r1_op;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;

  logic [OPW-1:0]   alu_s;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_f;
  logic             alu_ovf;
  logic             alu_take_branch;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_ovf;
  logic             rsp_branch;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
    output r0_ready, r1_ready,
    output alu_s, alu_a, alu_b,
    input  alu_f, alu_ovf, alu_take_branch,
    output rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_branch,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
    input  r0_ready, r1_ready,
    input  alu_s, alu_a, alu_b,
    output alu_f, alu_ovf, alu_take_branch,
    input  rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_branch,
    output rsp_ready
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; ties go to the requester not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit ALU (IDLE -> EXEC -> RESP).
// Optional per-requester sticky overflow: define ALU_ARB_STICKY_OVF_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_if.slave       bus,
  input  logic [NUM_REQ-1:0] ovf_clr,
  output logic [NUM_REQ-1:0] sticky_ovf,
  output logic               busy
);
  state_t             state, next_state;
  logic               last_grant;
  logic               cur_id;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] hs;
  logic               accept;
  logic               acc_id;

  logic [OPW-1:0]     s_q;
  logic [WIDTH-1:0]   a_q, b_q, f_q;
  logic               rsp_id_q, ovf_q, br_q;

  rr_arb2 u_rr (
    .valid      ({bus.r1_valid, bus.r0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.r0_ready = (state == IDLE) && !rst && grant[0];
  assign bus.r1_ready = (state == IDLE) && !rst && grant[1];
  assign hs           = {bus.r1_valid & bus.r1_ready, bus.r0_valid & bus.r0_ready};
  assign accept       = |hs;
  assign acc_id       = hs[1];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pointer starts at 1 so requester 0 wins the first tie; it moves only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      s_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (accept) begin
      last_grant <= acc_id;
      cur_id     <= acc_id;
      s_q        <= acc_id ? bus.r1_op : bus.r0_op;
      a_q        <= acc_id ? bus.r1_a  : bus.r0_a;
      b_q        <= acc_id ? bus.r1_b  : bus.r0_b;
    end
  end

  // Result fields keep their last values after the response is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q      <= '0;
      ovf_q    <= 1'b0;
      br_q     <= 1'b0;
      rsp_id_q <= 1'b0;
    end else if (state == EXEC) begin
      f_q      <= bus.alu_f;
      ovf_q    <= bus.alu_ovf;
      br_q     <= bus.alu_take_branch;
      rsp_id_q <= cur_id;
    end
  end

  assign bus.alu_s      = s_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_f      = f_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_branch = br_q;
  assign busy           = (state != IDLE);

`ifdef ALU_ARB_STICKY_OVF_EN
  logic [NUM_REQ-1:0] sticky_q;
  logic [NUM_REQ-1:0] sticky_set;

  always_comb begin
    sticky_set = '0;
    if (state == EXEC && bus.alu_ovf) sticky_set[cur_id] = 1'b1;
  end

  // Set is OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= (sticky_q & ~ovf_clr) | sticky_set;
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr;
  assign sticky_ovf     = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random traffic vs a timestamp model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_STICKY_OVF_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ovf_clr;
  logic [1:0] sticky_ovf;
  logic       busy;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ovf_clr    (ovf_clr),
    .sticky_ovf (sticky_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Requester drivers
  logic [1:0] v;
  logic [2:0] q_op [2];
  logic [7:0] q_a  [2];
  logic [7:0] q_b  [2];
  logic       reissue;
  logic       random_mode;

  assign bus.r0_valid = v[0];
  assign bus.r0_op    = q_op[0];
  assign bus.r0_a     = q_a[0];
  assign bus.r0_b     = q_b[0];
  assign bus.r1_valid = v[1];
  assign bus.r1_op    = q_op[1];
  assign bus.r1_a     = q_a[1];
  assign bus.r1_b     = q_b[1];

  // Behavioural ALU: {take_branch, ovf, f}
  function automatic logic [9:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] f;
    logic       ovf;
    ovf = 1'b0;
    case (op)
      3'd0: f = a & b;
      3'd1: begin f = a + b; ovf = (a[7] == b[7]) && (f[7] != a[7]); end
      3'd2: begin f = a - b; ovf = (a[7] != b[7]) && (f[7] != a[7]); end
      3'd3: f = a | b;
      3'd4: f = a ^ b;
      3'd5: f = ~a;
      3'd6: f = a << 1;
      default: f = b;
    endcase
    return {(f == 8'h00) || f[7], ovf, f};
  endfunction

  assign {bus.alu_take_branch, bus.alu_ovf, bus.alu_f} = alu_ref(bus.alu_s, bus.alu_a, bus.alu_b);

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an op accepted on the edge that starts interval acc_cyc is pending until
  // its response is consumed; the response is visible from interval acc_cyc+1 on.
  int         cyc;
  bit         pending;
  int         acc_cyc;
  logic       m_last, m_id, m_rsp_id, m_ovf, m_br;
  logic [2:0] m_s;
  logic [7:0] m_a, m_b, m_f;
  logic [1:0] m_sticky;
  int         served[$];

  task automatic model_reset();
    pending  = 1'b0;
    m_last   = 1'b1;
    m_id     = 1'b0;
    m_rsp_id = 1'b0;
    m_ovf    = 1'b0;
    m_br     = 1'b0;
    m_s      = '0;
    m_a      = '0;
    m_b      = '0;
    m_f      = '0;
    m_sticky = '0;
  endtask

  task automatic present(int n, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    v[n]    = 1'b1;
    q_op[n] = op;
    q_a[n]  = a;
    q_b[n]  = b;
  endtask

  task automatic present_rand(int n);
    present(n, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
  endtask

  // Entered at a negedge with inputs applied; returns at the following negedge.
  task automatic step();
    logic [1:0] exp_rdy, hs, sset;
    logic       exp_rv;
    #1;
    if (rst) model_reset();
    exp_rdy = 2'b00;
    if (!rst && !pending) begin
      if (v == 2'b11) exp_rdy[~m_last] = 1'b1;
      else            exp_rdy = v;
    end
    exp_rv = pending && (cyc > acc_cyc);

    check("r0_ready",   bus.r0_ready,   exp_rdy[0]);
    check("r1_ready",   bus.r1_ready,   exp_rdy[1]);
    check("rsp_valid",  bus.rsp_valid,  exp_rv);
    check("busy",       busy,           pending);
    check("alu_s",      bus.alu_s,      m_s);
    check("alu_a",      bus.alu_a,      m_a);
    check("alu_b",      bus.alu_b,      m_b);
    check("rsp_id",     bus.rsp_id,     m_rsp_id);
    check("rsp_f",      bus.rsp_f,      m_f);
    check("rsp_ovf",    bus.rsp_ovf,    m_ovf);
    check("rsp_branch", bus.rsp_branch, m_br);
    check("sticky_ovf", sticky_ovf,     m_sticky);

    if (bus.r0_valid && bus.r0_ready) served.push_back(0);
    if (bus.r1_valid && bus.r1_ready) served.push_back(1);

    hs   = exp_rdy & v;
    sset = 2'b00;
    if (!rst) begin
      if (hs != 2'b00) begin
        m_id    = hs[1];
        m_last  = hs[1];
        m_s     = q_op[m_id];
        m_a     = q_a[m_id];
        m_b     = q_b[m_id];
        pending = 1'b1;
        acc_cyc = cyc + 1;
      end else if (pending && cyc == acc_cyc) begin
        {m_br, m_ovf, m_f} = alu_ref(m_s, m_a, m_b);
        m_rsp_id = m_id;
        if (m_ovf) sset[m_id] = 1'b1;
      end else if (exp_rv && bus.rsp_ready) begin
        pending = 1'b0;
      end
      if (STICKY_ON) m_sticky = (m_sticky & ~ovf_clr) | sset;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);

    for (int n = 0; n < 2; n++) begin
      if (hs[n]) begin
        if (reissue) present_rand(n);
        else         v[n] = 1'b0;
      end
    end
    if (random_mode) begin
      rst           = ($urandom_range(0, 399) == 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      ovf_clr       = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      for (int n = 0; n < 2; n++) begin
        if (v[n] && $urandom_range(0, 19) == 0)       v[n] = 1'b0;
        else if (!v[n] && $urandom_range(0, 2) == 0)  present_rand(n);
      end
    end
  endtask

  task automatic drain(int n);
    v             = 2'b00;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    rst           = 1'b1;
    v             = 2'b00;
    reissue       = 1'b0;
    random_mode   = 1'b0;
    ovf_clr       = 2'b00;
    bus.rsp_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      q_op[n] = '0;
      q_a[n]  = '0;
      q_b[n]  = '0;
    end
    cyc     = 0;
    acc_cyc = 0;
    model_reset();

    // Reset state, including readies held low with requests pending
    @(negedge clk);
    present(0, 3'd1, 8'h11, 8'h22);
    present(1, 3'd2, 8'h33, 8'h44);
    step();
    step();
    rst = 1'b0;

    // Tie from reset: service alternates 0,1,0,1 with both held valid
    served.delete();
    reissue       = 1'b1;
    bus.rsp_ready = 1'b1;
    guard         = 0;
    while (served.size() < 4 && guard < 40) begin
      step();
      guard++;
    end
    reissue = 1'b0;
    check("tie_count", served.size(), 4);
    for (int i = 0; i < 4 && i < served.size(); i++) check($sformatf("tie_order%0d", i), served[i], i % 2);
    drain(4);

    // Single request: 05 + 03
    present(0, 3'd1, 8'h05, 8'h03);
    step();
    check("t1_alu_a", bus.alu_a, 8'h05);
    check("t1_alu_b", bus.alu_b, 8'h03);
    check("t1_rsp_valid_exec", bus.rsp_valid, 1'b0);
    step();
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_id", bus.rsp_id, 1'b0);
    check("t1_rsp_f", bus.rsp_f, 8'h08);
    check("t1_rsp_ovf", bus.rsp_ovf, 1'b0);
    drain(3);

    // Backpressure: hold rsp_ready low for 5 cycles with r1 waiting
    bus.rsp_ready = 1'b0;
    present(0, 3'd4, 8'hA5, 8'h0F);
    step();
    present(1, 3'd3, 8'h50, 8'h05);
    guard = 0;
    while (!bus.rsp_valid && guard < 10) begin
      step();
      guard++;
    end
    check("bp_rsp_seen", bus.rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_busy", busy, 1'b1);
      check("bp_r1_ready", bus.r1_ready, 1'b0);
      check("bp_rsp_f", bus.rsp_f, 8'hAA);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_rsp_drop", bus.rsp_valid, 1'b0);
    check("bp_next_accept", bus.r1_ready, 1'b1);
    drain(5);

    // Overflow and branch capture from requester 1, then sticky clear / set-wins
    present(1, 3'd1, 8'h7F, 8'h01);
    step();
    step();
    check("ovf_rsp_id", bus.rsp_id, 1'b1);
    check("ovf_rsp_f", bus.rsp_f, 8'h80);
    check("ovf_rsp_ovf", bus.rsp_ovf, 1'b1);
    check("ovf_rsp_branch", bus.rsp_branch, 1'b1);
    check("ovf_sticky_set", sticky_ovf, STICKY_ON ? 2'b10 : 2'b00);
    step();
    ovf_clr = 2'b10;
    step();
    ovf_clr = 2'b00;
    check("ovf_sticky_clr", sticky_ovf, 2'b00);
    present(1, 3'd1, 8'h7F, 8'h01);
    step();
    ovf_clr = 2'b10;
    step();
    ovf_clr = 2'b00;
    check("ovf_set_wins", sticky_ovf, STICKY_ON ? 2'b10 : 2'b00);
    drain(3);

    // Reset during EXEC discards the op; r0 wins the next tie
    present(0, 3'd2, 8'h10, 8'h01);
    step();
    rst = 1'b1;
    step();
    check("rx_rsp_valid", bus.rsp_valid, 1'b0);
    check("rx_busy", busy, 1'b0);
    check("rx_alu_a", bus.alu_a, 8'h00);
    rst = 1'b0;
    served.delete();
    present(0, 3'd0, 8'hF0, 8'h3C);
    present(1, 3'd0, 8'h0F, 8'h3C);
    step();
    check("rx_tie_winner", (served.size() > 0) ? served[0] : 9, 0);
    drain(8);

    // Random traffic
    random_mode = 1'b1;
    for (int i = 0; i < 4000; i++) step();
    random_mode = 1'b0;
    rst         = 1'b0;
    ovf_clr     = 2'b00;
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit combinational ALU. It accepts one operation at a time from either requester over a valid/ready handshake and registers the opcode and operands onto the ALU inputs. After one settle cycle it captures the result, overflow and branch flags, then returns them on a single tagged response channel with backpressure. It sits between the VIO/test front-end (or future datapath clients) and the ALU instance.

## Interface
- WIDTH, 8, operand and result width
- OPW, 3, ALU operation-select width
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- r0_valid / r1_valid  input  1  requester N has an operation pending
- r0_ready / r1_ready  output  1  arbiter accepts requester N this cycle
- r0_op / r1_op  input  OPW  ALU select for requester N
- r0_a, r0_b / r1_a, r1_b  input  WIDTH  operands for requester N
- alu_s  output  OPW  registered select to ALU
- alu_a, alu_b  output  WIDTH  registered operands to ALU
- alu_f  input  WIDTH  ALU result
- alu_ovf, alu_take_branch  input  1  ALU flags
- rsp_valid  output  1  response held valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester the response belongs to
- rsp_f  output  WIDTH  captured result
- rsp_ovf, rsp_branch  output  1  captured flags
- busy  output  1  high in EXEC or RESP
- ovf_clr  input  2  per-requester sticky-overflow clear
- sticky_ovf  output  2  per-requester sticky overflow (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: rN_ready = (state==IDLE) && !rst && grant==N; at most one ready is high per cycle. Grant rule: only one valid → that requester; both valid → the requester not granted last (last_grant). On the handshake (rN_valid & rN_ready): latch rN_op/a/b into alu_s/alu_a/alu_b, record id, update last_grant=N, go to EXEC.
- No valid in IDLE: alu_* hold their last values; last_grant unchanged.
- EXEC: one cycle; at its end capture alu_f, alu_ovf and alu_take_branch into rsp_f, rsp_ovf and rsp_branch, set rsp_id, assert rsp_valid, go to RESP.
- RESP: hold every rsp_* output stable until rsp_valid & rsp_ready; then clear rsp_valid and return to IDLE. rsp_f/flags/id retain their values after clearing.
- Requesters hold valid and payload stable until ready. A valid dropped before ready is simply not served.
- The arbiter never pipelines: no new accept while in EXEC or RESP, so both readies are 0 there.

## Timing
- Reset values: state IDLE, last_grant=1 (requester 0 wins the first tie), alu_s/alu_a/alu_b=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_ovf=0, rsp_branch=0, busy=0, sticky_ovf=0; r0_ready=r1_ready=0 while rst is high.
- Handshake at edge E0 → alu_* valid after E0 → result captured at E1, so rsp_valid is high after E1 (2-cycle latency).
- rsp_ready high at E2 → rsp_valid low after E2. The earliest next accept is at E3; peak throughput is 1 op / 3 cycles.
- rsp_ready high before rsp_valid has no effect.
- rst asserted mid-operation: the in-flight op and response are discarded immediately; no response is issued after reset.

## Configuration
- ALU_ARB_STICKY_OVF_EN defined:
  - sticky_ovf[rsp_id] sets at the EXEC→RESP capture when alu_ovf=1.
  - ovf_clr[N] clears bit N on the next edge.
  - Set and clear of the same bit in the same cycle → set wins.
- Not defined: sticky_ovf tied to 2'b00 and ovf_clr ignored; all other behaviour is identical.

## Structure
- Package alu_arb_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - constants NUM_REQ=2, ALU_W=8, ALU_OPW=3.
- Sub-module rr_arb2 holds the combinational two-way grant from valid[1:0] and last_grant. The pointer register stays in the parent and updates only on handshake.

## Test plan
- Single request, consumer ready: r0 op=3'b001 a=8'h05 b=8'h03, bench ALU drives f=8'h08 → r0_ready for 1 cycle, alu_a=8'h05/alu_b=8'h03 next cycle, rsp_valid 2 cycles after handshake with rsp_id=0, rsp_f=8'h08, rsp_ovf=0.
- Tie from reset: both valid simultaneously → r0 served first, then r1; with both held valid, service alternates 0,1,0,1 across four ops.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid → rsp_* stable, both readies 0, busy=1; release → rsp_valid drops next edge and the next accept happens one cycle later.
- Overflow/branch capture: r1 a=8'h7F b=8'h01, bench ALU drives f=8'h80, ovf=1, take_branch=1 → rsp_id=1, rsp_f=8'h80, rsp_ovf=1, rsp_branch=1; with the macro, sticky_ovf=2'b10, then ovf_clr=2'b10 → 2'b00; set and clear in the same cycle → remains set.
- Reset in EXEC: assert rst the cycle after a handshake → rsp_valid never rises, all outputs return to reset values, and r0 wins the next tie.
